// File: rtl/mac_requant_q35.sv
// mac_requant_q35
// Streaming dot-product stage feeding the tanh LUT. Accumulates signed
// Q3.5 x Q0.7 products over a vector framed by in_last. Rounds the Q.12 sum
// half-up to Q3.5, then saturates it to 8 bits. The result is presented on a
// valid/ready output port.
// Optional feature: define SAT_COUNT_EN to add the 16-bit saturating sat_cnt
// port, which counts saturated results.

module mac_requant_q35 #(
    parameter int ACC_W = 24,
    parameter int SHIFT = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] in_a,
    input  logic signed [7:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [7:0] out_data,
    output logic              out_sat
`ifdef SAT_COUNT_EN
    ,
    output logic [15:0]       sat_cnt
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   RND     = (ACC_W+1)'(1 << (SHIFT-1));
    localparam logic signed [ACC_W:0]   R_MAX   = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0]   R_MIN   = -(ACC_W+1)'(128);

    logic [1:0]              state;
    logic signed [ACC_W-1:0] acc;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W:0]   rq_wide;
    logic signed [ACC_W:0]   rq_shift;
    logic signed [7:0]       rq_data;
    logic                    rq_sat;
    logic                    accept;

    // Handshake: ready only outside HOLD and never while reset is held
    always_comb begin
        in_ready  = !reset && (state != ST_HOLD);
        out_valid = (state == ST_HOLD);
        accept    = in_valid && in_ready;
    end

    // Q3.12 product, its saturating sum with the accumulator, and the Q3.5 requant
    always_comb begin
        prod     = in_a * in_b;
        prod_ext = {{(ACC_W-16){prod[15]}}, prod};
        sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
            acc_sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            acc_sum = sum_wide[ACC_W-1:0];
        acc_next = (state == ST_IDLE) ? prod_ext : acc_sum;
        rq_wide  = {acc_next[ACC_W-1], acc_next} + RND;
        rq_shift = rq_wide >>> SHIFT;
        if (rq_shift > R_MAX) begin
            rq_data = 8'sd127;
            rq_sat  = 1'b1;
        end else if (rq_shift < R_MIN) begin
            rq_data = -8'sd128;
            rq_sat  = 1'b1;
        end else begin
            rq_data = rq_shift[7:0];
            rq_sat  = 1'b0;
        end
    end

    // Vector FSM: accumulate beats, capture the result on in_last, hold until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            acc      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        if (in_last) begin
                            out_data <= rq_data;
                            out_sat  <= rq_sat;
                            state    <= ST_HOLD;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SAT_COUNT_EN
    // Count saturated results as they enter HOLD; stick at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_cnt <= '0;
        else if (accept && in_last && rq_sat && (sat_cnt != 16'hFFFF))
            sat_cnt <= sat_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mac_requant_q35.sv
// tb_mac_requant_q35
// Directed-vector bench for mac_requant_q35. Expected values are hand-computed
// in Q3.5. Define SAT_COUNT_EN to also check the sat_cnt port.

module tb_mac_requant_q35;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_a;
    logic signed [7:0] in_b;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              out_sat;
`ifdef SAT_COUNT_EN
    logic [15:0]       sat_cnt;
`endif

    int checks;
    int errors;

    mac_requant_q35 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
`ifdef SAT_COUNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a report
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d required=%0d", tag, observed, expected);
        end
    endtask

    // One beat: must be accepted at the next rising edge
    task automatic applyStimulus(input int a, input int b, input bit last);
        checkOutput("in_ready_beat", int'(in_ready), 1);
        in_valid = 1'b1;
        in_a     = 8'(a);
        in_b     = 8'(b);
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Result must be valid the cycle after the last beat; then drain it
    task automatic expectResult(input string tag, input int data, input int sat);
        checkOutput({tag, "_valid"}, int'(out_valid), 1);
        checkOutput({tag, "_data"}, int'(out_data), data);
        checkOutput({tag, "_sat"}, int'(out_sat), sat);
        checkOutput({tag, "_ready_hold"}, int'(in_ready), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_drained"}, int'(out_valid), 0);
        checkOutput({tag, "_ready_idle"}, int'(in_ready), 1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        #1;
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_out_sat", int'(out_sat), 0);
`ifdef SAT_COUNT_EN
        checkOutput("rst_sat_cnt", int'(sat_cnt), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", int'(in_ready), 1);

        // 32*64 = 2048 -> (2048+64)>>7 = 16
        applyStimulus(32, 64, 1);
        expectResult("single", 16, 0);

        // Rounding: 64 -> 1, 63 -> 0, -64 -> 0
        applyStimulus(1, 64, 1);
        expectResult("rnd_up", 1, 0);
        applyStimulus(1, 63, 1);
        expectResult("rnd_down", 0, 0);
        applyStimulus(-1, 64, 1);
        expectResult("rnd_neg", 0, 0);

        // 2048 - 512 - 200 = 1336 -> 1400>>7 = 10
        applyStimulus(32, 64, 0);
        applyStimulus(-16, 32, 0);
        applyStimulus(10, -20, 1);
        expectResult("multi", 10, 0);

        // 16129 + 63 = 16192 -> 16256>>7 = 127 exactly, not clamped
        applyStimulus(127, 127, 0);
        applyStimulus(1, 63, 1);
        expectResult("edge_pos", 127, 0);

        // -16256 - 128 = -16384 -> -16320>>>7 = -128 exactly, not clamped
        applyStimulus(-128, 127, 0);
        applyStimulus(-128, 1, 1);
        expectResult("edge_neg", -128, 0);

        // 8 x 16129 = 129032 -> 1008, clamps to 127
        for (int i = 0; i < 8; i++) applyStimulus(127, 127, (i == 7));
        expectResult("sat_pos", 127, 1);
`ifdef SAT_COUNT_EN
        checkOutput("sat_cnt_1", int'(sat_cnt), 1);
`endif

        // 8 x -16256 = -130048 -> -1016, clamps to -128
        for (int i = 0; i < 8; i++) applyStimulus(-128, 127, (i == 7));
        expectResult("sat_neg", -128, 1);
`ifdef SAT_COUNT_EN
        checkOutput("sat_cnt_2", int'(sat_cnt), 2);
`endif

        // 520 x 16384 overflows 24 bits; the accumulator must clamp high, not wrap
        for (int i = 0; i < 520; i++) applyStimulus(-128, -128, (i == 519));
        expectResult("acc_clamp", 127, 1);
`ifdef SAT_COUNT_EN
        checkOutput("sat_cnt_3", int'(sat_cnt), 3);
`endif

        // Backpressure, with a beat offered during HOLD that must be ignored
        applyStimulus(32, 64, 1);
        in_valid = 1'b1;
        in_a     = 8'sd127;
        in_b     = 8'sd127;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", int'(out_valid), 1);
            checkOutput("bp_data", int'(out_data), 16);
            checkOutput("bp_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_release_valid", int'(out_valid), 0);
        checkOutput("bp_release_ready", int'(in_ready), 1);
        applyStimulus(1, 64, 1);
        expectResult("after_bp", 1, 0);

        // Reset after 3 beats of a 4-beat vector discards the partial sum
        for (int i = 0; i < 3; i++) applyStimulus(32, 64, 0);
        reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        checkOutput("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midrst_ready_after", int'(in_ready), 1);
`ifdef SAT_COUNT_EN
        checkOutput("midrst_sat_cnt", int'(sat_cnt), 0);
`endif
        applyStimulus(32, 64, 1);
        expectResult("post_midrst", 16, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
